// File: rtl/lcd_fb_arbiter_if.sv
// ---------------------------------------------------------------------------
// lcd_fb_arbiter_if
// Bundles every non-clock signal of the LCD frame-buffer arbiter: the
// scan-out read port, the host command port and the single-port BRAM port.
//   slave  : the arbiter's view (display/host requests in, BRAM commands out)
//   master : the environment's view (drives requests and BRAM read data)
// Parameters: ADDR_W word address width, DATA_W pixel width, DEPTH host
// command FIFO entries (power of 2, sets the width of oHOST_CNT).
// ---------------------------------------------------------------------------
interface lcd_fb_arbiter_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  // display scan-out read port
  logic              iDISP_REQ;
  logic [ADDR_W-1:0] iDISP_ADDR;
  logic              oDISP_VALID;
  logic [DATA_W-1:0] oDISP_DATA;

  // host command port
  logic              iHOST_VALID;
  logic              oHOST_READY;
  logic              iHOST_WE;
  logic [ADDR_W-1:0] iHOST_ADDR;
  logic [DATA_W-1:0] iHOST_WDATA;
  logic              oHOST_RVALID;
  logic [DATA_W-1:0] oHOST_RDATA;
  logic [CNT_W-1:0]  oHOST_CNT;

  // single-port BRAM port
  logic [ADDR_W-1:0] oMEM_ADDR;
  logic              oMEM_WE;
  logic [DATA_W-1:0] oMEM_WDATA;
  logic [DATA_W-1:0] iMEM_RDATA;

  modport slave (
    input  iDISP_REQ, iDISP_ADDR,
    output oDISP_VALID, oDISP_DATA,
    input  iHOST_VALID, iHOST_WE, iHOST_ADDR, iHOST_WDATA,
    output oHOST_READY, oHOST_RVALID, oHOST_RDATA, oHOST_CNT,
    output oMEM_ADDR, oMEM_WE, oMEM_WDATA,
    input  iMEM_RDATA
  );

  modport master (
    output iDISP_REQ, iDISP_ADDR,
    input  oDISP_VALID, oDISP_DATA,
    output iHOST_VALID, iHOST_WE, iHOST_ADDR, iHOST_WDATA,
    input  oHOST_READY, oHOST_RVALID, oHOST_RDATA, oHOST_CNT,
    input  oMEM_ADDR, oMEM_WE, oMEM_WDATA,
    output iMEM_RDATA
  );
endinterface

// File: rtl/lcd_fb_arbiter.sv
// ---------------------------------------------------------------------------
// lcd_fb_arbiter
// Shares one single-port frame-buffer BRAM between LCD scan-out reads and a
// host command stream. The display has absolute priority; host commands are
// buffered in a DEPTH-entry FIFO and executed strictly in order whenever the
// display is not requesting. All BRAM controls are registered, and every
// read returns its data exactly three cycles after its grant, tagged with its
// owner so the result lands on the display or host read port.
// Ports:
//   iCLK  : sole clock, rising edge
//   inRST : synchronous active-low reset
//   bus   : lcd_fb_arbiter_if.slave (display, host and BRAM signals)
// ---------------------------------------------------------------------------
module lcd_fb_arbiter #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic               iCLK,
  input  logic               inRST,
  lcd_fb_arbiter_if.slave    bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {
    GNT_IDLE = 2'd0,
    GNT_DISP = 2'd1,
    GNT_HOST = 2'd2
  } grant_e;

  typedef enum logic {
    OWN_DISP = 1'b0,
    OWN_HOST = 1'b1
  } owner_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } cmd_t;

  typedef struct packed {
    logic   valid;
    owner_e owner;
  } tag_t;

  // FIFO state
  cmd_t             fifo_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ready_q, ready_d;

  // read tag pipeline: stage 0 is the BRAM address cycle, stage 1 the BRAM
  // data cycle; the output registers below form the third stage
  tag_t             tag_q [2];
  tag_t             tag_d;

  // registered BRAM controls and read results
  logic [ADDR_W-1:0] mem_addr_q;
  logic              mem_we_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              disp_valid_q;
  logic [DATA_W-1:0] disp_data_q;
  logic              host_rvalid_q;
  logic [DATA_W-1:0] host_rdata_q;

  // combinational arbitration
  grant_e grant_s;
  logic   push_s;
  logic   pop_s;
  cmd_t   head_s;
  cmd_t   cmd_in_s;

  // Arbitration, FIFO bookkeeping and next read tag.
  always_comb begin
    cmd_in_s = '{we: bus.iHOST_WE, addr: bus.iHOST_ADDR, data: bus.iHOST_WDATA};
    head_s   = fifo_q[rd_ptr_q];
    // ready is a registered copy of (count < DEPTH), so a full FIFO refuses
    // a push even in a cycle where it pops
    push_s   = bus.iHOST_VALID && ready_q;

    if (bus.iDISP_REQ) begin
      grant_s = GNT_DISP;
    end else if (cnt_q != {CNT_W{1'b0}}) begin
      grant_s = GNT_HOST;
    end else begin
      grant_s = GNT_IDLE;
    end
    pop_s = (grant_s == GNT_HOST);

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    cnt_d   = cnt_q + CNT_W'(push_s) - CNT_W'(pop_s);
    ready_d = (cnt_d < CNT_W'(DEPTH));

    case (grant_s)
      GNT_DISP: tag_d = '{valid: 1'b1, owner: OWN_DISP};
      GNT_HOST: tag_d = '{valid: ~head_s.we, owner: OWN_HOST};
      default:  tag_d = '{valid: 1'b0, owner: OWN_DISP};
    endcase
  end

  // FIFO storage; contents need no reset because count gates every read.
  always_ff @(posedge iCLK) begin
    if (push_s) begin
      fifo_q[wr_ptr_q] <= cmd_in_s;
    end
  end

  // Control state, BRAM command registers and read result registers.
  always_ff @(posedge iCLK) begin
    if (!inRST) begin
      wr_ptr_q      <= {PTR_W{1'b0}};
      rd_ptr_q      <= {PTR_W{1'b0}};
      cnt_q         <= {CNT_W{1'b0}};
      ready_q       <= 1'b1;
      tag_q[0]      <= '0;
      tag_q[1]      <= '0;
      mem_addr_q    <= {ADDR_W{1'b0}};
      mem_we_q      <= 1'b0;
      mem_wdata_q   <= {DATA_W{1'b0}};
      disp_valid_q  <= 1'b0;
      disp_data_q   <= {DATA_W{1'b0}};
      host_rvalid_q <= 1'b0;
      host_rdata_q  <= {DATA_W{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      tag_q[0] <= tag_d;
      tag_q[1] <= tag_q[0];

      // idle holds address and write data so the BRAM inputs stay quiet
      case (grant_s)
        GNT_DISP: begin
          mem_addr_q <= bus.iDISP_ADDR;
          mem_we_q   <= 1'b0;
        end
        GNT_HOST: begin
          mem_addr_q <= head_s.addr;
          mem_we_q   <= head_s.we;
          if (head_s.we) begin
            mem_wdata_q <= head_s.data;
          end
        end
        default: begin
          mem_we_q <= 1'b0;
        end
      endcase

      // stage 1 tag lines up with iMEM_RDATA for the same read
      disp_valid_q  <= tag_q[1].valid && (tag_q[1].owner == OWN_DISP);
      host_rvalid_q <= tag_q[1].valid && (tag_q[1].owner == OWN_HOST);
      if (tag_q[1].valid && (tag_q[1].owner == OWN_DISP)) begin
        disp_data_q <= bus.iMEM_RDATA;
      end
      if (tag_q[1].valid && (tag_q[1].owner == OWN_HOST)) begin
        host_rdata_q <= bus.iMEM_RDATA;
      end
    end
  end

  assign bus.oHOST_READY  = ready_q;
  assign bus.oHOST_CNT    = cnt_q;
  assign bus.oMEM_ADDR    = mem_addr_q;
  assign bus.oMEM_WE      = mem_we_q;
  assign bus.oMEM_WDATA   = mem_wdata_q;
  assign bus.oDISP_VALID  = disp_valid_q;
  assign bus.oDISP_DATA   = disp_data_q;
  assign bus.oHOST_RVALID = host_rvalid_q;
  assign bus.oHOST_RDATA  = host_rdata_q;

endmodule

// File: tb/tb_lcd_fb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_lcd_fb_arbiter
// Directed bench for lcd_fb_arbiter. A small synchronous BRAM model (one
// cycle read latency, initial word at address a = 0xC000 + a) answers the
// arbiter. Each scenario task drives inputs #1 after the rising edge and
// checks the registered outputs at the same point.
// ---------------------------------------------------------------------------
module tb_lcd_fb_arbiter;
  localparam int ADDR_W = 19;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;

  logic iCLK = 1'b0;
  logic inRST;
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  lcd_fb_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  lcd_fb_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .iCLK  (iCLK),
    .inRST (inRST),
    .bus   (bus)
  );

  always #5 iCLK = ~iCLK;

  // BRAM model: read-before-write, data one cycle after the address
  logic [15:0] bram [256];
  bit          bram_init_done;
  always @(posedge iCLK) begin
    if (!bram_init_done) begin
      for (int i = 0; i < 256; i++) bram[i] <= 16'hC000 + 16'(i);
      bram_init_done <= 1'b1;
    end else begin
      if (bus.oMEM_WE) bram[bus.oMEM_ADDR[7:0]] <= bus.oMEM_WDATA;
      bus.iMEM_RDATA <= bram[bus.oMEM_ADDR[7:0]];
    end
  end

  task automatic cyc();
    @(posedge iCLK);
    #1;
  endtask

  task automatic idle_inputs();
    bus.iDISP_REQ   = 1'b0;
    bus.iDISP_ADDR  = '0;
    bus.iHOST_VALID = 1'b0;
    bus.iHOST_WE    = 1'b0;
    bus.iHOST_ADDR  = '0;
    bus.iHOST_WDATA = '0;
  endtask

  task automatic host_cmd(input logic we, input int addr, input logic [15:0] data);
    bus.iHOST_VALID = 1'b1;
    bus.iHOST_WE    = we;
    bus.iHOST_ADDR  = ADDR_W'(addr);
    bus.iHOST_WDATA = data;
  endtask

  task automatic test_reset();
    inRST = 1'b0;
    idle_inputs();
    cyc();
    cyc();
    inRST = 1'b1;
    cyc();
    total_cnt++; if (bus.oDISP_VALID !== 1'b0) $display("FAIL reset_disp_valid: got %b want 0", bus.oDISP_VALID); else pass_cnt++;
    total_cnt++; if (bus.oHOST_RVALID !== 1'b0) $display("FAIL reset_host_rvalid: got %b want 0", bus.oHOST_RVALID); else pass_cnt++;
    total_cnt++; if (bus.oMEM_WE !== 1'b0) $display("FAIL reset_mem_we: got %b want 0", bus.oMEM_WE); else pass_cnt++;
    total_cnt++; if (bus.oMEM_ADDR !== 19'd0) $display("FAIL reset_mem_addr: got %0h want 0", bus.oMEM_ADDR); else pass_cnt++;
    total_cnt++; if (bus.oMEM_WDATA !== 16'h0000) $display("FAIL reset_mem_wdata: got %h want 0000", bus.oMEM_WDATA); else pass_cnt++;
    total_cnt++; if (bus.oHOST_CNT !== 3'd0) $display("FAIL reset_cnt: got %0d want 0", bus.oHOST_CNT); else pass_cnt++;
    total_cnt++; if (bus.oHOST_READY !== 1'b1) $display("FAIL reset_ready: got %b want 1", bus.oHOST_READY); else pass_cnt++;
    total_cnt++; if ({bus.oDISP_DATA, bus.oHOST_RDATA} !== 32'h0) $display("FAIL reset_rdata: got %h want 0", {bus.oDISP_DATA, bus.oHOST_RDATA}); else pass_cnt++;
  endtask

  // host write addr 5 / 0xABCD: BRAM write two cycles after accept
  task automatic test_host_write();
    idle_inputs();
    host_cmd(1'b1, 5, 16'hABCD);
    total_cnt++; if (bus.oHOST_READY !== 1'b1) $display("FAIL wr_ready: got %b want 1", bus.oHOST_READY); else pass_cnt++;
    cyc();
    idle_inputs();
    total_cnt++; if (bus.oHOST_CNT !== 3'd1) $display("FAIL wr_cnt1: got %0d want 1", bus.oHOST_CNT); else pass_cnt++;
    cyc();
    total_cnt++; if (bus.oMEM_WE !== 1'b1) $display("FAIL wr_we: got %b want 1", bus.oMEM_WE); else pass_cnt++;
    total_cnt++; if (bus.oMEM_ADDR !== 19'd5) $display("FAIL wr_addr: got %0d want 5", bus.oMEM_ADDR); else pass_cnt++;
    total_cnt++; if (bus.oMEM_WDATA !== 16'hABCD) $display("FAIL wr_wdata: got %h want abcd", bus.oMEM_WDATA); else pass_cnt++;
    total_cnt++; if (bus.oHOST_CNT !== 3'd0) $display("FAIL wr_cnt0: got %0d want 0", bus.oHOST_CNT); else pass_cnt++;
    cyc();
    total_cnt++; if (bus.oMEM_WE !== 1'b0) $display("FAIL idle_we: got %b want 0", bus.oMEM_WE); else pass_cnt++;
    total_cnt++; if ({bus.oMEM_ADDR, bus.oMEM_WDATA} !== {19'd5, 16'hABCD}) $display("FAIL idle_hold: got %0d/%h want 5/abcd", bus.oMEM_ADDR, bus.oMEM_WDATA); else pass_cnt++;
  endtask

  // write 0x1234 to addr 7 then read it back: RVALID 3 cycles after grant
  task automatic test_write_read();
    idle_inputs();
    host_cmd(1'b1, 7, 16'h1234);
    cyc();
    host_cmd(1'b0, 7, 16'h0000);
    cyc();
    idle_inputs();
    // read pushed while the write popped in the same cycle
    total_cnt++; if (bus.oHOST_CNT !== 3'd1) $display("FAIL wrrd_cnt: got %0d want 1", bus.oHOST_CNT); else pass_cnt++;
    total_cnt++; if ({bus.oMEM_WE, bus.oMEM_ADDR} !== {1'b1, 19'd7}) $display("FAIL wrrd_wr: got %b/%0d want 1/7", bus.oMEM_WE, bus.oMEM_ADDR); else pass_cnt++;
    for (int k = 1; k <= 4; k++) begin
      cyc();
      total_cnt++;
      if (bus.oHOST_RVALID !== (k == 3)) $display("FAIL wrrd_rvalid_t%0d: got %b want %b", k, bus.oHOST_RVALID, (k == 3));
      else pass_cnt++;
      if (k == 1) begin
        total_cnt++; if ({bus.oMEM_WE, bus.oMEM_ADDR} !== {1'b0, 19'd7}) $display("FAIL wrrd_rd: got %b/%0d want 0/7", bus.oMEM_WE, bus.oMEM_ADDR); else pass_cnt++;
      end
      if (k == 3) begin
        total_cnt++; if (bus.oHOST_RDATA !== 16'h1234) $display("FAIL wrrd_rdata: got %h want 1234", bus.oHOST_RDATA); else pass_cnt++;
      end
    end
  endtask

  // display holds the BRAM for 10 cycles while the host offers 6 writes
  task automatic test_disp_burst();
    int  sent = 0;
    int  we_seen = 0;
    for (int i = 0; i < 10; i++) begin
      idle_inputs();
      bus.iDISP_REQ  = 1'b1;
      bus.iDISP_ADDR = ADDR_W'(100 + i);
      if (sent < 6) host_cmd(1'b1, 20 + sent, 16'h5000 + 16'(sent));
      if (bus.oMEM_WE === 1'b1) we_seen++;
      if (bus.iHOST_VALID && bus.oHOST_READY === 1'b1) sent++;
      cyc();
    end
    idle_inputs();
    if (bus.oMEM_WE === 1'b1) we_seen++;
    total_cnt++; if (sent !== 4) $display("FAIL burst_accepted: got %0d want 4", sent); else pass_cnt++;
    total_cnt++; if (bus.oHOST_READY !== 1'b0) $display("FAIL burst_ready: got %b want 0", bus.oHOST_READY); else pass_cnt++;
    total_cnt++; if (bus.oHOST_CNT !== 3'd4) $display("FAIL burst_cnt: got %0d want 4", bus.oHOST_CNT); else pass_cnt++;
    total_cnt++; if (we_seen !== 0) $display("FAIL burst_no_we: got %0d write cycles want 0", we_seen); else pass_cnt++;
    for (int d = 1; d <= 5; d++) begin
      cyc();
      total_cnt++;
      if (bus.oMEM_WE !== (d <= 4)) $display("FAIL drain_we_d%0d: got %b want %b", d, bus.oMEM_WE, (d <= 4));
      else pass_cnt++;
      if (d <= 4) begin
        total_cnt++;
        if (bus.oMEM_ADDR !== ADDR_W'(19 + d)) $display("FAIL drain_addr_d%0d: got %0d want %0d", d, bus.oMEM_ADDR, 19 + d);
        else pass_cnt++;
      end
    end
    total_cnt++; if ({bus.oHOST_CNT, bus.oHOST_READY} !== {3'd0, 1'b1}) $display("FAIL drain_empty: got %0d/%b want 0/1", bus.oHOST_CNT, bus.oHOST_READY); else pass_cnt++;
  endtask

  // display request toggles while two host reads (addr 20, 21) are queued
  task automatic test_interleave();
    bit          exp_dv [10];
    bit          exp_hv [10];
    logic [15:0] exp_d  [10];
    for (int c = 0; c < 10; c++) begin
      exp_dv[c] = 1'b0;
      exp_hv[c] = 1'b0;
      exp_d[c]  = 16'h0000;
    end
    exp_dv[3] = 1'b1; exp_d[3] = 16'hC01E;  // disp addr 30, granted c0
    exp_dv[4] = 1'b1; exp_d[4] = 16'hC01F;  // disp addr 31, granted c1
    exp_hv[5] = 1'b1; exp_d[5] = 16'h5000;  // host addr 20, granted c2
    exp_dv[6] = 1'b1; exp_d[6] = 16'hC028;  // disp addr 40, granted c3
    exp_hv[7] = 1'b1; exp_d[7] = 16'h5001;  // host addr 21, granted c4
    exp_dv[8] = 1'b1; exp_d[8] = 16'hC029;  // disp addr 41, granted c5
    for (int c = 0; c < 10; c++) begin
      idle_inputs();
      case (c)
        0: begin bus.iDISP_REQ = 1'b1; bus.iDISP_ADDR = 19'd30; host_cmd(1'b0, 20, 16'h0000); end
        1: begin bus.iDISP_REQ = 1'b1; bus.iDISP_ADDR = 19'd31; host_cmd(1'b0, 21, 16'h0000); end
        3: begin bus.iDISP_REQ = 1'b1; bus.iDISP_ADDR = 19'd40; end
        5: begin bus.iDISP_REQ = 1'b1; bus.iDISP_ADDR = 19'd41; end
        default: ;
      endcase
      total_cnt++;
      if ({bus.oDISP_VALID, bus.oHOST_RVALID} !== {exp_dv[c], exp_hv[c]})
        $display("FAIL ilv_valid_c%0d: got disp=%b host=%b want disp=%b host=%b", c, bus.oDISP_VALID, bus.oHOST_RVALID, exp_dv[c], exp_hv[c]);
      else pass_cnt++;
      if (exp_dv[c]) begin
        total_cnt++; if (bus.oDISP_DATA !== exp_d[c]) $display("FAIL ilv_disp_data_c%0d: got %h want %h", c, bus.oDISP_DATA, exp_d[c]); else pass_cnt++;
      end
      if (exp_hv[c]) begin
        total_cnt++; if (bus.oHOST_RDATA !== exp_d[c]) $display("FAIL ilv_host_data_c%0d: got %h want %h", c, bus.oHOST_RDATA, exp_d[c]); else pass_cnt++;
      end
      cyc();
    end
  endtask

  // one-cycle reset with 3 writes queued and display reads in flight
  task automatic test_reset_mid();
    int bad = 0;
    for (int c = 0; c < 4; c++) begin
      idle_inputs();
      bus.iDISP_REQ  = 1'b1;
      bus.iDISP_ADDR = ADDR_W'(60 + c);
      if (c < 3) host_cmd(1'b1, 50 + c, 16'hEE00 + 16'(c));
      cyc();
    end
    idle_inputs();
    total_cnt++; if (bus.oHOST_CNT !== 3'd3) $display("FAIL rstmid_queued: got %0d want 3", bus.oHOST_CNT); else pass_cnt++;
    inRST = 1'b0;
    cyc();
    inRST = 1'b1;
    total_cnt++; if ({bus.oHOST_CNT, bus.oHOST_READY} !== {3'd0, 1'b1}) $display("FAIL rstmid_cnt: got %0d/%b want 0/1", bus.oHOST_CNT, bus.oHOST_READY); else pass_cnt++;
    for (int c = 0; c < 8; c++) begin
      if (bus.oDISP_VALID !== 1'b0 || bus.oHOST_RVALID !== 1'b0 || bus.oMEM_WE !== 1'b0 || bus.oHOST_CNT !== 3'd0) bad++;
      cyc();
    end
    total_cnt++; if (bad !== 0) $display("FAIL rstmid_quiet: got %0d active cycles want 0", bad); else pass_cnt++;
    // queued write to addr 50 must not have reached the BRAM
    bus.iDISP_REQ  = 1'b1;
    bus.iDISP_ADDR = 19'd50;
    cyc();
    idle_inputs();
    cyc();
    cyc();
    total_cnt++; if ({bus.oDISP_VALID, bus.oDISP_DATA} !== {1'b1, 16'hC032}) $display("FAIL rstmid_old_data: got %b/%h want 1/c032", bus.oDISP_VALID, bus.oDISP_DATA); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_host_write();
    test_write_read();
    test_disp_burst();
    test_interleave();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
